// File: rtl/execute_stage_pipe.sv
// Registered execute stage: ALU, branch resolution and an iterative shift-add
// multiplier behind a valid/ready handshake, feeding the EX/MEM register.
module execute_stage_pipe #(
  parameter int XLEN   = 64,
  parameter bit MUL_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] read_data1,
  input  logic [XLEN-1:0] read_data2,
  input  logic [XLEN-1:0] imm_out,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] PC4,
  input  logic [1:0]      ALUOp,
  input  logic            ALUSrc,
  input  logic            Branch,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] next_pc,
  output logic            branch_taken
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL,
    OP_SRL, OP_SRA, OP_SLT, OP_SLTU, OP_MUL
  } alu_op_e;

  state_e          state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic            branch_taken_q, branch_taken_d;
  logic [XLEN-1:0] alu_result_q, alu_result_d;
  logic [XLEN-1:0] store_data_q, store_data_d;
  logic [XLEN-1:0] next_pc_q, next_pc_d;
  logic [XLEN-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [SHW-1:0]  cnt_q, cnt_d;

  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_b, alu_res, target;
  logic [SHW-1:0]  shamt;
  logic            out_free, accept, taken;
  alu_op_e         op;
  logic            unused_inst;

  assign funct7      = inst[31:25];
  assign funct3      = inst[14:12];
  assign unused_inst = ^{inst[24:15], inst[11:0]};
  assign op_b        = ALUSrc ? imm_out : read_data2;
  assign shamt       = op_b[SHW-1:0];
  assign target      = pc + (imm_out << 1);
  assign out_free    = !out_valid_q || out_ready;
  assign in_ready    = (state_q == S_IDLE) && out_free && !flush;
  assign accept      = in_valid && in_ready;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    op = OP_ADD;
    case (ALUOp)
      2'b01: op = OP_SUB;
      2'b10: begin
        case ({funct7, funct3})
          10'b0100000_000: op = OP_SUB;
          10'b0000000_111: op = OP_AND;
          10'b0000000_110: op = OP_OR;
          10'b0000000_100: op = OP_XOR;
          10'b0000000_001: op = OP_SLL;
          10'b0000000_101: op = OP_SRL;
          10'b0100000_101: op = OP_SRA;
          10'b0000000_010: op = OP_SLT;
          10'b0000000_011: op = OP_SLTU;
          10'b0000001_000: op = MUL_EN ? OP_MUL : OP_ADD;
          default:         op = OP_ADD;
        endcase
      end
      2'b11: begin
        case (funct3)
          3'b111:  op = OP_AND;
          3'b110:  op = OP_OR;
          3'b100:  op = OP_XOR;
          3'b001:  op = OP_SLL;
          3'b101:  op = inst[30] ? OP_SRA : OP_SRL;
          3'b010:  op = OP_SLT;
          3'b011:  op = OP_SLTU;
          default: op = OP_ADD;
        endcase
      end
      default: op = OP_ADD;
    endcase
  end

  always_comb begin
    alu_res = read_data1 + op_b;
    case (op)
      OP_SUB:  alu_res = read_data1 - op_b;
      OP_AND:  alu_res = read_data1 & op_b;
      OP_OR:   alu_res = read_data1 | op_b;
      OP_XOR:  alu_res = read_data1 ^ op_b;
      OP_SLL:  alu_res = read_data1 << shamt;
      OP_SRL:  alu_res = read_data1 >> shamt;
      OP_SRA:  alu_res = XLEN'($signed(read_data1) >>> shamt);
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(read_data1) < $signed(op_b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (read_data1 < op_b)};
      default: alu_res = read_data1 + op_b;
    endcase
  end

  // Branches always compare the two register values, never the immediate.
  always_comb begin
    taken = 1'b0;
    if (Branch) begin
      case (funct3)
        3'b000:  taken = (read_data1 == read_data2);
        3'b001:  taken = (read_data1 != read_data2);
        3'b100:  taken = ($signed(read_data1) <  $signed(read_data2));
        3'b101:  taken = ($signed(read_data1) >= $signed(read_data2));
        3'b110:  taken = (read_data1 <  read_data2);
        3'b111:  taken = (read_data1 >= read_data2);
        default: taken = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d        = state_q;
    out_valid_d    = out_valid_q && !out_ready;
    alu_result_d   = alu_result_q;
    store_data_d   = store_data_q;
    next_pc_d      = next_pc_q;
    branch_taken_d = branch_taken_q;
    mcand_d        = mcand_q;
    mplier_d       = mplier_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          // Side fields load now; accept implies the old result is gone or leaving.
          store_data_d   = read_data2;
          next_pc_d      = taken ? target : PC4;
          branch_taken_d = taken;
          if (op == OP_MUL) begin
            state_d  = S_MUL;
            mcand_d  = read_data1;
            mplier_d = op_b;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            alu_result_d = alu_res;
            out_valid_d  = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHW'(1);
        if (cnt_q == SHW'(XLEN-1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_free) begin
          alu_result_d = acc_q;
          out_valid_d  = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      out_valid_d = 1'b0;
      state_d     = S_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of all others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      out_valid_q    <= 1'b0;
      branch_taken_q <= 1'b0;
      alu_result_q   <= '0;
      store_data_q   <= '0;
      next_pc_q      <= '0;
    end else begin
      state_q        <= state_d;
      out_valid_q    <= out_valid_d;
      branch_taken_q <= branch_taken_d;
      alu_result_q   <= alu_result_d;
      store_data_q   <= store_data_d;
      next_pc_q      <= next_pc_d;
    end
  end

  // NOTE: multiplier working registers carry no reset; they are always
  // initialised on entry to S_MUL before they are read.
  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    acc_q    <= acc_d;
    cnt_q    <= cnt_d;
  end

  assign out_valid    = out_valid_q;
  assign alu_result   = alu_result_q;
  assign store_data   = store_data_q;
  assign next_pc      = next_pc_q;
  assign branch_taken = branch_taken_q;
endmodule

// File: tb/tb_execute_stage_pipe.sv
// Self-checking bench for execute_stage_pipe: directed scenarios plus random
// ALU/branch traffic compared with an arithmetic reference model.
module tb_execute_stage_pipe;
  localparam int XLEN = 64;
  typedef logic [XLEN-1:0] word_t;
  typedef struct packed {
    word_t alu;
    word_t sd;
    word_t npc;
    logic  taken;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] inst;
  word_t       read_data1, read_data2, imm_out, pc, PC4;
  logic [1:0]  ALUOp;
  logic        ALUSrc, Branch, branch_taken;
  word_t       alu_result, store_data, next_pc;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [9:0] rkeys [9] = '{10'b0000000_000, 10'b0100000_000, 10'b0000000_111,
                            10'b0000000_110, 10'b0000000_100, 10'b0000000_001,
                            10'b0000000_101, 10'b0100000_101, 10'b0000000_010};

  execute_stage_pipe #(.XLEN(XLEN), .MUL_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .read_data1(read_data1), .read_data2(read_data2), .imm_out(imm_out),
    .pc(pc), .PC4(PC4), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .Branch(Branch),
    .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
    .store_data(store_data), .next_pc(next_pc), .branch_taken(branch_taken)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic word_t model_alu(logic [1:0] aluop, logic [31:0] ins, word_t a, word_t b);
    logic [6:0] f7;
    logic [2:0] f3;
    int sh;
    f7 = ins[31:25];
    f3 = ins[14:12];
    sh = int'(b[5:0]);
    if (aluop == 2'b00) return a + b;
    if (aluop == 2'b01) return a - b;
    // I-type reuses the R-type table; only the right shift looks at bit 30.
    if (aluop == 2'b11) f7 = (f3 == 3'b101 && ins[30]) ? 7'b0100000 : 7'b0000000;
    case ({f7, f3})
      10'b0100000_000: return a - b;
      10'b0000000_111: return a & b;
      10'b0000000_110: return a | b;
      10'b0000000_100: return a ^ b;
      10'b0000000_001: return a << sh;
      10'b0000000_101: return a >> sh;
      10'b0100000_101: return word_t'($signed(a) >>> sh);
      10'b0000000_010: return ($signed(a) < $signed(b)) ? word_t'(1) : word_t'(0);
      10'b0000000_011: return (a < b) ? word_t'(1) : word_t'(0);
      10'b0000001_000: return a * b;
      default:         return a + b;
    endcase
  endfunction

  function automatic logic model_taken(logic [2:0] f3, word_t a, word_t b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return !($signed(a) < $signed(b));
      3'b110:  return a < b;
      3'b111:  return !(a < b);
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t model(logic [1:0] aluop, logic [31:0] ins, logic alusrc, logic br,
                                 word_t rs1, word_t rs2, word_t imm, word_t pcv, word_t pc4v);
    exp_t e;
    e.alu   = model_alu(aluop, ins, rs1, alusrc ? imm : rs2);
    e.sd    = rs2;
    e.taken = br && model_taken(ins[14:12], rs1, rs2);
    e.npc   = e.taken ? pcv + imm + imm : pc4v;
    return e;
  endfunction

  function automatic word_t rand_word();
    case ($urandom_range(0, 3))
      0:       return word_t'($urandom_range(0, 20));
      1:       return 64'h8000_0000_0000_0000;
      2:       return ~word_t'($urandom_range(0, 5));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [1:0] aluop, logic [31:0] ins, logic alusrc, logic br,
                       word_t rs1, word_t rs2, word_t imm, word_t pcv);
    in_valid   = 1'b1;
    ALUOp      = aluop;
    inst       = ins;
    ALUSrc     = alusrc;
    Branch     = br;
    read_data1 = rs1;
    read_data2 = rs2;
    imm_out    = imm;
    pc         = pcv;
    PC4        = pcv + 4;
  endtask

  function automatic logic [31:0] r_inst(logic [6:0] f7, logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'h33};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(2'b00, 32'h0, 1'b0, 1'b0, '0, '0, '0, '0);
    in_valid = 1'b0;
    cyc(); cyc();
    tests_run++;
    if ({out_valid, branch_taken, alu_result, store_data, next_pc} !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: got ov=%b bt=%b alu=%h sd=%h npc=%h, required all zero",
               out_valid, branch_taken, alu_result, store_data, next_pc);
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    // Reset must also clear a held result.
    out_ready = 1'b0;
    drive(2'b00, 32'h0, 1'b0, 1'b0, 64'd5, 64'd9, '0, 64'h40);
    cyc();
    in_valid = 1'b0;
    reset    = 1'b1;
    cyc();
    tests_run++;
    if ({out_valid, branch_taken, alu_result, store_data, next_pc} !== '0) begin
      tests_failed++;
      $display("FAIL reset_held_result: got ov=%b alu=%h sd=%h npc=%h, required all zero",
               out_valid, alu_result, store_data, next_pc);
    end
    reset = 1'b0; out_ready = 1'b1;
    cyc();
  endtask

  task automatic test_add();
    drive(2'b10, r_inst(7'b0000000, 3'b000), 1'b0, 1'b0, 64'd5, 64'd7, 64'd99, 64'h200);
    cyc();
    in_valid = 1'b0;
    tests_run++;
    if ({out_valid, alu_result, store_data, next_pc, branch_taken} !==
        {1'b1, 64'd12, 64'd7, 64'h204, 1'b0}) begin
      tests_failed++;
      $display("FAIL add_rr: got ov=%b alu=%0d sd=%0d npc=%h bt=%b, required 1/12/7/204/0",
               out_valid, alu_result, store_data, next_pc, branch_taken);
    end
    cyc();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_drain: out_valid got %b required 0", out_valid);
    end
  endtask

  task automatic test_branch();
    drive(2'b01, r_inst(7'b0, 3'b100), 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 64'd8, 64'h100);
    cyc();
    tests_run++;
    if ({out_valid, branch_taken, next_pc, alu_result} !==
        {1'b1, 1'b1, 64'h110, 64'hFFFF_FFFF_FFFF_FFFB}) begin
      tests_failed++;
      $display("FAIL blt_taken: got ov=%b bt=%b npc=%h alu=%h, required 1/1/110/fffffffffffffffb",
               out_valid, branch_taken, next_pc, alu_result);
    end
    drive(2'b01, r_inst(7'b0, 3'b110), 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 64'd8, 64'h100);
    cyc();
    in_valid = 1'b0;
    tests_run++;
    if ({out_valid, branch_taken, next_pc} !== {1'b1, 1'b0, 64'h104}) begin
      tests_failed++;
      $display("FAIL bltu_not_taken: got ov=%b bt=%b npc=%h, required 1/0/104",
               out_valid, branch_taken, next_pc);
    end
    cyc();
  endtask

  task automatic test_random_alu();
    logic [1:0]  aluop;
    logic [31:0] ins;
    exp_t        e;
    for (int i = 0; i < 300; i++) begin
      aluop = 2'($urandom_range(0, 3));
      ins   = $urandom;
      if (aluop == 2'b10 && $urandom_range(0, 3) != 0)
        {ins[31:25], ins[14:12]} = rkeys[$urandom_range(0, 8)];
      if (aluop == 2'b10 && {ins[31:25], ins[14:12]} == 10'b0000001_000) ins[12] = 1'b1;
      drive(aluop, ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            rand_word(), rand_word(), rand_word(), {$urandom, $urandom});
      e = model(ALUOp, inst, ALUSrc, Branch, read_data1, read_data2, imm_out, pc, PC4);
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL rand_in_ready[%0d]: got %b required 1", i, in_ready);
      end
      cyc();
      tests_run++;
      if ({out_valid, e.alu, e.sd, e.npc, e.taken} !==
          {1'b1, alu_result, store_data, next_pc, branch_taken}) begin
        tests_failed++;
        $display("FAIL rand_op[%0d] aluop=%b inst=%h: got ov=%b alu=%h sd=%h npc=%h bt=%b, required alu=%h sd=%h npc=%h bt=%b",
                 i, ALUOp, inst, out_valid, alu_result, store_data, next_pc, branch_taken,
                 e.alu, e.sd, e.npc, e.taken);
      end
    end
    in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(2'b10, r_inst(7'b0, 3'b000), 1'b0, 1'b0, 64'd100, 64'd23, '0, 64'h300);
    cyc();
    drive(2'b11, r_inst(7'b0, 3'b100), 1'b1, 1'b0, 64'hF0F0, 64'd1, 64'h0FF0, 64'h304);
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_in_ready_low: got %b required 0", in_ready);
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      tests_run++;
      if ({out_valid, alu_result, next_pc} !== {1'b1, 64'd123, 64'h304}) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: got ov=%b alu=%0d npc=%h, required 1/123/304",
                 k, out_valid, alu_result, next_pc);
      end
    end
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_release_in_ready: got %b required 1", in_ready);
    end
    cyc();
    in_valid = 1'b0;
    tests_run++;
    if ({out_valid, alu_result, next_pc} !== {1'b1, 64'hFF00, 64'h308}) begin
      tests_failed++;
      $display("FAIL bp_second: got ov=%b alu=%h npc=%h, required 1/ff00/308",
               out_valid, alu_result, next_pc);
    end
    cyc();
  endtask

  task automatic run_mul(word_t a, word_t b, string name);
    int bad_cycle;
    word_t pcv;
    bad_cycle = 0;
    pcv = {$urandom, $urandom};
    drive(2'b10, r_inst(7'b0000001, 3'b000), 1'b0, 1'b0, a, b, 64'd77, pcv);
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_accept: in_ready got %b required 1", name, in_ready);
    end
    cyc();
    in_valid = 1'b0;
    for (int k = 1; k <= XLEN + 1; k++) begin
      if ((in_ready !== 1'b0 || out_valid !== 1'b0) && bad_cycle == 0) bad_cycle = k;
      cyc();
    end
    tests_run++;
    if (bad_cycle != 0) begin
      tests_failed++;
      $display("FAIL %s_busy: in_ready/out_valid not 0 at cycle %0d, required 0 through cycle %0d",
               name, bad_cycle, XLEN + 1);
    end
    tests_run++;
    if ({out_valid, in_ready, alu_result, store_data, next_pc, branch_taken} !==
        {1'b1, 1'b1, a * b, b, pcv + 64'd4, 1'b0}) begin
      tests_failed++;
      $display("FAIL %s_result: got ov=%b ir=%b alu=%h sd=%h npc=%h bt=%b, required 1/1/%h/%h/%h/0",
               name, out_valid, in_ready, alu_result, store_data, next_pc, branch_taken,
               a * b, b, pcv + 64'd4);
    end
    cyc();
  endtask

  task automatic test_mul();
    run_mul(64'hFFFF_FFFF_FFFF_FFFD, 64'd7, "mul_neg3x7");
    for (int i = 0; i < 3; i++) run_mul(rand_word(), rand_word(), "mul_rand");
  endtask

  task automatic test_flush();
    int seen;
    seen = 0;
    drive(2'b10, r_inst(7'b0000001, 3'b000), 1'b0, 1'b0, 64'd1234, 64'd5678, '0, 64'h500);
    cyc();
    in_valid = 1'b0;
    for (int k = 1; k < 10; k++) cyc();
    flush = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_in_ready_low: got %b required 0", in_ready);
    end
    cyc();
    flush = 1'b0;
    #1;
    tests_run++;
    if ({in_ready, out_valid} !== 2'b10) begin
      tests_failed++;
      $display("FAIL flush_recover: got ir=%b ov=%b, required ir=1 ov=0", in_ready, out_valid);
    end
    for (int k = 0; k < XLEN + 6; k++) begin
      if (out_valid !== 1'b0) seen++;
      cyc();
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL flush_discard: out_valid high for %0d cycles, required 0", seen);
    end
    drive(2'b10, r_inst(7'b0, 3'b000), 1'b0, 1'b0, 64'd1, 64'd1, '0, 64'h600);
    cyc();
    tests_run++;
    if ({out_valid, alu_result} !== {1'b1, 64'd2}) begin
      tests_failed++;
      $display("FAIL flush_then_add: got ov=%b alu=%0d, required 1/2", out_valid, alu_result);
    end
    // Instruction offered together with flush while a result is held.
    out_ready = 1'b0;
    drive(2'b10, r_inst(7'b0, 3'b000), 1'b0, 1'b0, 64'd3, 64'd3, '0, 64'h700);
    flush = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_blocks_accept: in_ready got %b required 0", in_ready);
    end
    cyc();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_squash_output: out_valid got %b required 0", out_valid);
    end
    cyc();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_no_late_accept: out_valid got %b required 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_mul();
    drive(2'b10, r_inst(7'b0, 3'b000), 1'b0, 1'b0, 64'd40, 64'd2, '0, 64'h800);
    cyc();
    drive(2'b10, r_inst(7'b0000001, 3'b000), 1'b0, 1'b0, 64'd9, 64'd9, '0, 64'h804);
    cyc();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, branch_taken, alu_result, store_data, next_pc, in_ready} !==
        {1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_mid_mul: got ov=%b bt=%b alu=%h sd=%h npc=%h ir=%b, required zeros and ir=1",
               out_valid, branch_taken, alu_result, store_data, next_pc, in_ready);
    end
    drive(2'b10, r_inst(7'b0100000, 3'b101), 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'd63, '0, 64'h900);
    cyc();
    in_valid = 1'b0;
    tests_run++;
    if ({out_valid, alu_result} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFF}) begin
      tests_failed++;
      $display("FAIL sra_after_reset: got ov=%b alu=%h, required 1/ffffffffffffffff",
               out_valid, alu_result);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_random_alu();
    test_back_to_back();
    test_mul();
    test_flush();
    test_reset_mid_mul();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
